apcpu_decoder_pipe: RTL and testbench
=====================================

Name: apcpu_decoder_pipe

Overview:
Parametrised, pipelined successor to the APCPU instruction decoder. It accepts instruction words over a valid/ready handshake into a small input FIFO and splits each word into ALU code, immediate data and three register selects. It adds sign-extension and a two-word extended-immediate form, and it holds its output under backpressure. It sits between instruction fetch and the ALU/register file.

Parameters:
INSTR_W, 32, instruction word width
OPC_W, 8, opcode field width, taken from the MSBs of the word
DATA_W, 32, DecoderData width; DATA_W >= INSTR_W-OPC_W and DATA_W <= INSTR_W
REG_SEL_W, 3, width of each register select
AP_W, 3, APSel width
DEPTH, 2, input FIFO depth; a power of two, >= 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous pipeline flush, active high
in_valid  in  1  InstructionBus/APSelBus valid
in_ready  out  1  FIFO can accept a word
InstructionBus  in  INSTR_W  instruction word
APSelBus  in  AP_W  AP select sampled with the word
out_valid  out  1  decoded instruction valid
out_ready  in  1  consumer accepts the decoded instruction
AluCode  out  OPC_W  opcode field
DecoderData  out  DATA_W  immediate data
RegSelX  out  REG_SEL_W  bits [REG_SEL_W-1:0]
RegSelY  out  REG_SEL_W  bits [2*REG_SEL_W-1:REG_SEL_W]
RegSelZ  out  REG_SEL_W  bits [3*REG_SEL_W-1:2*REG_SEL_W]
APSelOut  out  AP_W  APSelBus captured with the opcode word
ExtImm  out  1  DecoderData came from an extension word

Behaviour:
- Reset: while rst is low, all outputs are 0, including in_ready. The FIFO is emptied and the FSM goes to S_OP. Operation resumes on the first edge after rst deasserts.
- Input side:
  - A word is pushed into the FIFO on an edge where in_valid && in_ready.
  - in_ready = !fifo_full. There is no push-while-full bypass, even if a pop happens in the same cycle.
- Opcode word fields:
  - opc = word[INSTR_W-1 -: OPC_W].
  - EXT flag = opc[OPC_W-1].
  - SEXT flag = opc[OPC_W-2].
  - imm = word[INSTR_W-OPC_W-1:0].
- FSM, state S_OP: a FIFO pop happens when the FIFO is non-empty and (!out_valid || out_ready).
  - If EXT=0: load the output register.
    - AluCode=opc.
    - DecoderData = imm, sign-extended if SEXT=1, else zero-extended, to DATA_W.
    - RegSel X/Y/Z from the word, APSelOut from the captured APSel, ExtImm=0, out_valid=1.
  - If EXT=1: latch opc, the RegSels and APSel into holding registers and go to S_EXT. The output is not loaded.
- FSM, state S_EXT: the next pop supplies the extension word; the pop rule is the same as in S_OP.
  - Load the output: DecoderData = ext_word[DATA_W-1:0]; AluCode, RegSels and APSelOut from the holding registers; ExtImm=1; out_valid=1.
  - Return to S_OP. The SEXT flag is ignored here.
- Output hold: once out_valid is 1, all outputs stay stable until the edge with out_valid && out_ready.
  - If the FIFO is empty on that edge, out_valid drops to 0 and the data outputs hold their last value.
  - If a pop happens on that edge, the next result loads on the same edge, giving full throughput.
- Latency: a word pushed at edge k shows out_valid=1 after edge k+1 if the pipe is idle. An EXT pair pushed at edges k and k+1 shows out_valid after edge k+2.
- Flush: synchronous and has priority over everything else.
  - On a flush edge: the FIFO empties, the FSM goes to S_OP, out_valid goes to 0, and any push on that edge is discarded.
  - in_ready stays per FIFO state; it reads 1 after the flush.
- Reset mid-EXT: the FSM returns to S_OP. The next word is treated as an opcode word.

Decomposition:
- Shared package apcpu_decoder_pkg holds:
  - State encoding (S_OP, S_EXT).
  - EXT and SEXT bit-offset constants, as offsets from the opcode MSB.
  - Field-offset helper functions for the RegSel slices.
- Sub-module decoder_fifo: a synchronous FIFO with parameters WIDTH=INSTR_W+AP_W and DEPTH, and outputs full, empty and head data.
- The top level contains the FSM, the holding registers and the output register.

Test Plan:
- Basic decode: push 32'h00003202 with APSel=3, out_ready=1 -> after edge k+1: AluCode=8'h00, DecoderData=32'h00003202, X=2, Y=0, Z=0, APSelOut=3, ExtImm=0.
- Back-to-back: push 32'h00003202 then 32'h01129403 on consecutive edges with out_ready=1 -> two consecutive out_valid beats; the second has AluCode=8'h01, DecoderData=32'h00129403, X=3, Y=0, Z=0.
- Sign-extend: push 32'h40800001 -> AluCode=8'h40, DecoderData=32'hFF800001, X=1. Then push 32'h00800001 -> DecoderData=32'h00800001.
- Extended immediate: push 32'h85000000 with APSel=5, then 32'hDEADBEEF -> exactly one output beat: AluCode=8'h85, DecoderData=32'hDEADBEEF, ExtImm=1, APSelOut=5.
- Backpressure (DEPTH=2): out_ready=0, offer 4 words -> 3 accepted (1 in the output register, 2 in the FIFO), in_ready=0, outputs stable. Then out_ready=1 -> words drain in order, one per cycle.
- Flush and reset during EXT:
  - Flush: push 32'h85000000, then assert flush -> out_valid=0. Next push 32'h00003202 decodes as an opcode: AluCode=0, ExtImm=0.
  - Reset: repeat with rst low for 1 cycle -> all outputs 0, in_ready=0 during reset, same decode afterwards.

Source files
------------

// File: rtl/apcpu_decoder_pkg.sv
// Shared definitions for the APCPU pipelined decoder.
//   dec_state_t  : decoder FSM states (opcode word / extension word)
//   EXT_OFS      : EXT flag position, counted down from the opcode MSB
//   SEXT_OFS     : SEXT flag position, counted down from the opcode MSB
//   reg_sel_lo() : low bit index of register select number idx
package apcpu_decoder_pkg;

    typedef enum logic [0:0] {
        S_OP  = 1'b0,
        S_EXT = 1'b1
    } dec_state_t;

    localparam int EXT_OFS  = 0;
    localparam int SEXT_OFS = 1;

    function automatic int reg_sel_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/apcpu_decoder_pipe_fifo.sv
// Small synchronous FIFO holding {APSel, instruction word} entries.
//   clk, rst_n     : clock, async active-low reset
//   flush          : synchronous clear, wins over push/pop
//   push, wdata    : write request (ignored when full)
//   pop            : read request (ignored when empty)
//   full, empty    : status
//   rdata          : head entry (valid when !empty)
module decoder_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/apcpu_decoder_pipe.sv
// Pipelined APCPU instruction decoder.
// Words enter a small FIFO over in_valid/in_ready and are split into ALU code,
// immediate data and three register selects. An opcode with EXT set takes its
// immediate from the following word. The output register holds under
// backpressure and reloads on the consuming edge for full throughput.
//   clk, rst            : clock, async active-low reset
//   flush               : synchronous pipeline flush (highest priority)
//   in_valid/in_ready   : input handshake for InstructionBus + APSelBus
//   out_valid/out_ready : output handshake for the decoded fields
//   AluCode, DecoderData, RegSelX/Y/Z, APSelOut, ExtImm : decoded fields
//
// state | meaning
// S_OP  | next popped word is an opcode word
// S_EXT | next popped word is the extension immediate for the held opcode
module apcpu_decoder_pipe
    import apcpu_decoder_pkg::*;
#(
    parameter int INSTR_W   = 32,
    parameter int OPC_W     = 8,
    parameter int DATA_W    = 32,
    parameter int REG_SEL_W = 3,
    parameter int AP_W      = 3,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_W-1:0]   InstructionBus,
    input  logic [AP_W-1:0]      APSelBus,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OPC_W-1:0]     AluCode,
    output logic [DATA_W-1:0]    DecoderData,
    output logic [REG_SEL_W-1:0] RegSelX,
    output logic [REG_SEL_W-1:0] RegSelY,
    output logic [REG_SEL_W-1:0] RegSelZ,
    output logic [AP_W-1:0]      APSelOut,
    output logic                 ExtImm
);
    localparam int IMM_W = INSTR_W - OPC_W;
    localparam int FW    = INSTR_W + AP_W;

    logic              fifo_full, fifo_empty, fifo_push, pop;
    logic [FW-1:0]     fifo_rdata;
    logic [INSTR_W-1:0] head_word;
    logic [AP_W-1:0]   head_ap;
    logic [OPC_W-1:0]  opc;
    logic [IMM_W-1:0]  imm;
    logic              ext_flag, sext_flag;
    logic [DATA_W-1:0] imm_data;
    logic [REG_SEL_W-1:0] head_x, head_y, head_z;

    dec_state_t           state_q, state_d;
    logic [OPC_W-1:0]     hold_opc_q, hold_opc_d;
    logic [REG_SEL_W-1:0] hold_x_q, hold_x_d, hold_y_q, hold_y_d, hold_z_q, hold_z_d;
    logic [AP_W-1:0]      hold_ap_q, hold_ap_d;

    logic                 valid_q, valid_d;
    logic [OPC_W-1:0]     alu_q, alu_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [REG_SEL_W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [AP_W-1:0]      ap_q, ap_d;
    logic                 ext_q, ext_d;

    // Gated by rst so in_ready reads 0 while reset is held.
    assign in_ready  = rst && !fifo_full;
    assign fifo_push = in_valid && in_ready;

    decoder_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .flush (flush),
        .push  (fifo_push),
        .pop   (pop),
        .wdata ({APSelBus, InstructionBus}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .rdata (fifo_rdata)
    );

    assign {head_ap, head_word} = fifo_rdata;
    assign opc       = head_word[INSTR_W-1 -: OPC_W];
    assign imm       = head_word[IMM_W-1:0];
    assign ext_flag  = opc[OPC_W-1-EXT_OFS];
    assign sext_flag = opc[OPC_W-1-SEXT_OFS];
    assign head_x    = head_word[reg_sel_lo(0, REG_SEL_W) +: REG_SEL_W];
    assign head_y    = head_word[reg_sel_lo(1, REG_SEL_W) +: REG_SEL_W];
    assign head_z    = head_word[reg_sel_lo(2, REG_SEL_W) +: REG_SEL_W];
    assign imm_data  = sext_flag ? DATA_W'($signed(imm)) : DATA_W'(imm);

    // Same pop rule in both states: room downstream or the output is leaving.
    assign pop = !fifo_empty && (!valid_q || out_ready) && !flush;

    always_comb begin
        state_d    = state_q;
        hold_opc_d = hold_opc_q;
        hold_x_d   = hold_x_q;
        hold_y_d   = hold_y_q;
        hold_z_d   = hold_z_q;
        hold_ap_d  = hold_ap_q;
        valid_d    = valid_q && !out_ready;
        alu_d      = alu_q;
        data_d     = data_q;
        x_d        = x_q;
        y_d        = y_q;
        z_d        = z_q;
        ap_d       = ap_q;
        ext_d      = ext_q;
        if (flush) begin
            state_d = S_OP;
            valid_d = 1'b0;
        end else if (pop) begin
            case (state_q)
                S_OP: begin
                    if (ext_flag) begin
                        hold_opc_d = opc;
                        hold_x_d   = head_x;
                        hold_y_d   = head_y;
                        hold_z_d   = head_z;
                        hold_ap_d  = head_ap;
                        state_d    = S_EXT;
                    end else begin
                        valid_d = 1'b1;
                        alu_d   = opc;
                        data_d  = imm_data;
                        x_d     = head_x;
                        y_d     = head_y;
                        z_d     = head_z;
                        ap_d    = head_ap;
                        ext_d   = 1'b0;
                    end
                end
                S_EXT: begin
                    valid_d = 1'b1;
                    alu_d   = hold_opc_q;
                    data_d  = head_word[DATA_W-1:0];
                    x_d     = hold_x_q;
                    y_d     = hold_y_q;
                    z_d     = hold_z_q;
                    ap_d    = hold_ap_q;
                    ext_d   = 1'b1;
                    state_d = S_OP;
                end
                default: state_d = S_OP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_OP;
            hold_opc_q <= '0;
            hold_x_q   <= '0;
            hold_y_q   <= '0;
            hold_z_q   <= '0;
            hold_ap_q  <= '0;
            valid_q    <= 1'b0;
            alu_q      <= '0;
            data_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            ap_q       <= '0;
            ext_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_opc_q <= hold_opc_d;
            hold_x_q   <= hold_x_d;
            hold_y_q   <= hold_y_d;
            hold_z_q   <= hold_z_d;
            hold_ap_q  <= hold_ap_d;
            valid_q    <= valid_d;
            alu_q      <= alu_d;
            data_q     <= data_d;
            x_q        <= x_d;
            y_q        <= y_d;
            z_q        <= z_d;
            ap_q       <= ap_d;
            ext_q      <= ext_d;
        end
    end

    assign out_valid   = valid_q;
    assign AluCode     = alu_q;
    assign DecoderData = data_q;
    assign RegSelX     = x_q;
    assign RegSelY     = y_q;
    assign RegSelZ     = z_q;
    assign APSelOut    = ap_q;
    assign ExtImm      = ext_q;

endmodule

// File: tb/tb_apcpu_decoder_pipe.sv
module tb_apcpu_decoder_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] InstructionBus, DecoderData;
    logic [2:0]  APSelBus, RegSelX, RegSelY, RegSelZ, APSelOut;
    logic [7:0]  AluCode;
    logic        ExtImm;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    apcpu_decoder_pipe dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .InstructionBus (InstructionBus),
        .APSelBus       (APSelBus),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .AluCode        (AluCode),
        .DecoderData    (DecoderData),
        .RegSelX        (RegSelX),
        .RegSelY        (RegSelY),
        .RegSelZ        (RegSelZ),
        .APSelOut       (APSelOut),
        .ExtImm         (ExtImm)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one word for a single edge, then drop in_valid.
    task automatic push(input logic [31:0] w, input logic [2:0] ap);
        InstructionBus = w;
        APSelBus       = ap;
        in_valid       = 1'b1;
        step();
        in_valid       = 1'b0;
    endtask

    // Push into an idle pipe and wait the one extra edge for the result.
    task automatic send1(input logic [31:0] w, input logic [2:0] ap);
        push(w, ap);
        step();
    endtask

    logic [31:0] bp_words [4];
    logic        bp_ready [4];

    initial begin
        bp_words[0] = 32'h02000011;
        bp_words[1] = 32'h03000022;
        bp_words[2] = 32'h04000033;
        bp_words[3] = 32'h05000044;
        bp_ready[0] = 1'b1;
        bp_ready[1] = 1'b1;
        bp_ready[2] = 1'b1;
        bp_ready[3] = 1'b0;

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        InstructionBus = '0; APSelBus = '0;
        step(); step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu", 32'(AluCode), 32'd0);
        rst = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic decode with latency check
        push(32'h00003202, 3'd3);
        chk("basic_lat", 32'(out_valid), 32'd0);
        step();
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_alu", 32'(AluCode), 32'h00);
        chk("basic_data", DecoderData, 32'h00003202);
        chk("basic_x", 32'(RegSelX), 32'd2);
        chk("basic_y", 32'(RegSelY), 32'd0);
        chk("basic_z", 32'(RegSelZ), 32'd0);
        chk("basic_ap", 32'(APSelOut), 32'd3);
        chk("basic_ext", 32'(ExtImm), 32'd0);
        step();
        chk("basic_drain", 32'(out_valid), 32'd0);

        // Back-to-back
        InstructionBus = 32'h00003202; APSelBus = 3'd1; in_valid = 1'b1;
        step();
        InstructionBus = 32'h01129403; APSelBus = 3'd2;
        step();
        in_valid = 1'b0;
        chk("b2b_v1", 32'(out_valid), 32'd1);
        chk("b2b_alu1", 32'(AluCode), 32'h00);
        step();
        chk("b2b_v2", 32'(out_valid), 32'd1);
        chk("b2b_alu2", 32'(AluCode), 32'h01);
        chk("b2b_data2", DecoderData, 32'h00129403);
        chk("b2b_x2", 32'(RegSelX), 32'd3);
        chk("b2b_y2", 32'(RegSelY), 32'd0);
        chk("b2b_z2", 32'(RegSelZ), 32'd0);
        step();
        chk("b2b_drain", 32'(out_valid), 32'd0);

        // Sign / zero extension
        send1(32'h40800001, 3'd0);
        chk("sext_alu", 32'(AluCode), 32'h40);
        chk("sext_data", DecoderData, 32'hFF800001);
        chk("sext_x", 32'(RegSelX), 32'd1);
        send1(32'h00800001, 3'd0);
        chk("zext_data", DecoderData, 32'h00800001);
        step();

        // Extended immediate: APSel taken from the opcode word
        push(32'h85000000, 3'd5);
        push(32'hDEADBEEF, 3'd2);
        chk("ext_lat", 32'(out_valid), 32'd0);
        step();
        chk("ext_valid", 32'(out_valid), 32'd1);
        chk("ext_alu", 32'(AluCode), 32'h85);
        chk("ext_data", DecoderData, 32'hDEADBEEF);
        chk("ext_flag", 32'(ExtImm), 32'd1);
        chk("ext_ap", 32'(APSelOut), 32'd5);
        step();
        chk("ext_one_beat", 32'(out_valid), 32'd0);
        chk("ext_hold_data", DecoderData, 32'hDEADBEEF);

        // Backpressure: 4 offered, 3 accepted
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            InstructionBus = bp_words[i];
            APSelBus       = 3'(i);
            in_valid       = 1'b1;
            chk($sformatf("bp_ready%0d", i), 32'(in_ready), 32'(bp_ready[i]));
            step();
        end
        in_valid = 1'b0;
        step(); step();
        chk("bp_full", 32'(in_ready), 32'd0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_stable_alu", 32'(AluCode), 32'h02);
        chk("bp_stable_data", DecoderData, 32'h00000011);
        out_ready = 1'b1;
        step();
        chk("bp_drain_b", 32'(AluCode), 32'h03);
        chk("bp_drain_b_v", 32'(out_valid), 32'd1);
        step();
        chk("bp_drain_c", 32'(AluCode), 32'h04);
        chk("bp_drain_c_ap", 32'(APSelOut), 32'd2);
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_ready_back", 32'(in_ready), 32'd1);

        // Flush during EXT, with a push on the flush edge discarded
        push(32'h85000000, 3'd5);
        step();
        flush = 1'b1; InstructionBus = 32'h7F000000; in_valid = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        step();
        chk("flush_discard", 32'(out_valid), 32'd0);
        send1(32'h00003202, 3'd3);
        chk("flush_next_v", 32'(out_valid), 32'd1);
        chk("flush_next_alu", 32'(AluCode), 32'h00);
        chk("flush_next_ext", 32'(ExtImm), 32'd0);
        chk("flush_next_data", DecoderData, 32'h00003202);

        // Reset during EXT
        send1(32'h01129403, 3'd1);
        push(32'h85000000, 3'd5);
        step();
        chk("prerst_hold_alu", 32'(AluCode), 32'h01);
        chk("prerst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_alu", 32'(AluCode), 32'd0);
        chk("midrst_data", DecoderData, 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b1;
        step();
        send1(32'h00003202, 3'd3);
        chk("rst_next_v", 32'(out_valid), 32'd1);
        chk("rst_next_alu", 32'(AluCode), 32'h00);
        chk("rst_next_ext", 32'(ExtImm), 32'd0);
        chk("rst_next_data", DecoderData, 32'h00003202);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
